// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-master memory port arbiter.
//   state_t          : arbiter FSM states (IDLE / BUSY / DONE)
//   ARB_M0 / ARB_M1  : master indices (0 = Processor core, 1 = loader/debug agent)
//   ABORT_DATA       : read data returned to the owner when a transaction times out
//   TIMEOUT_DEFAULT  : default number of BUSY cycles allowed without iMemRdy
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic [31:0] ABORT_DATA = 32'h0000_0000;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: watchdog for a single memory transaction.
//   iClk    in  : clock, rising edge
//   nRst    in  : synchronous active-low reset
//   clear   in  : zero the count (held high whenever no transaction is in flight)
//   enable  in  : count this cycle (high while the arbiter is BUSY)
//   expired out : high during the TIMEOUT_CYCLES-th enabled cycle, so the abort
//                 lands on the edge that ends that cycle
// TIMEOUT_CYCLES = 0 builds no counter and ties expired low.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic iClk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{iClk, nRst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      // Count only reaches TIMEOUT_CYCLES-1 before the arbiter leaves BUSY.
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge iClk) begin
        if (!nRst) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && !expired) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign expired = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between master 0 (Processor core)
// and master 1 (loader/debug agent), one transaction at a time.
//
// Handshake: a master requests by raising Read or Write (both high = write)
// and holds Addr/Data/strobes stable until its one-cycle oMxRdy pulse. The
// arbiter samples requests only in IDLE; a request raised in BUSY or DONE
// simply waits. The memory completes by raising iMemRdy for one cycle while
// a strobe is presented; the arbiter holds the memory port constant until then.
//
// Ports:
//   iClk, nRst                    clock, synchronous active-low reset
//   iMxAddr/iMxData/iMxRead/iMxWrite   master x request (x = 0, 1)
//   oMxData/oMxRdy                read data and completion pulse to master x
//   oMemAddr/oMemData/oMemRead/oMemWrite  registered memory port
//   iMemData/iMemRdy              memory read data and completion
//   oGrant                        one-hot current owner, 00 = none
//   oTimeout                      sticky abort flag, cleared only by reset
//   dbg_state                     current FSM state (mem_arb_pkg::state_t)
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// master 0 always wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iM0Addr,
  input  logic [31:0] iM0Data,
  input  logic        iM0Read,
  input  logic        iM0Write,
  input  logic [31:0] iM1Addr,
  input  logic [31:0] iM1Data,
  input  logic        iM1Read,
  input  logic        iM1Write,
  output logic [31:0] oM0Data,
  output logic        oM0Rdy,
  output logic [31:0] oM1Data,
  output logic        oM1Rdy,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic [1:0]  oGrant,
  output logic        oTimeout,
  output logic [1:0]  dbg_state
);

  state_t state, state_nx;

  logic        req0, req1, win, owner;
  logic        expired;
  logic [31:0] ret_data;
  logic        capture;

  logic [31:0] mem_addr_nx, mem_data_nx, m0_data_nx, m1_data_nx;
  logic        mem_read_nx, mem_write_nx, m0_rdy_nx, m1_rdy_nx, timeout_nx;
  logic [1:0]  grant_nx;

  assign req0  = iM0Read | iM0Write;
  assign req1  = iM1Read | iM1Write;
  // oGrant is only non-zero in BUSY, which is the only state that uses owner.
  assign owner = oGrant[1] ? ARB_M1 : ARB_M0;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  always_comb begin
    win = req0 ? ARB_M0 : ARB_M1;
    if (req0 && req1) begin
      win = (last_grant == ARB_M0) ? ARB_M1 : ARB_M0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      last_grant <= ARB_M1;
    end else if (state == ST_IDLE && (req0 || req1)) begin
      last_grant <= win;
    end
  end
`else
  assign win = req0 ? ARB_M0 : ARB_M1;
`endif

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .iClk   (iClk),
    .nRst   (nRst),
    .clear  (state != ST_BUSY),
    .enable (state == ST_BUSY),
    .expired(expired)
  );

  // iMemRdy beats a same-cycle expiry. An abort returns ABORT_DATA to the
  // owner whether it was reading or writing; a normal write leaves data alone.
  assign ret_data = iMemRdy ? iMemData : ABORT_DATA;
  assign capture  = iMemRdy ? oMemRead : 1'b1;

  always_comb begin
    state_nx     = state;
    mem_addr_nx  = oMemAddr;
    mem_data_nx  = oMemData;
    mem_read_nx  = oMemRead;
    mem_write_nx = oMemWrite;
    grant_nx     = oGrant;
    m0_data_nx   = oM0Data;
    m1_data_nx   = oM1Data;
    m0_rdy_nx    = 1'b0;
    m1_rdy_nx    = 1'b0;
    timeout_nx   = oTimeout;

    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_nx = ST_BUSY;
          if (win == ARB_M0) begin
            mem_addr_nx  = iM0Addr;
            mem_data_nx  = iM0Data;
            mem_write_nx = iM0Write;
            mem_read_nx  = iM0Read & ~iM0Write;
            grant_nx     = 2'b01;
          end else begin
            mem_addr_nx  = iM1Addr;
            mem_data_nx  = iM1Data;
            mem_write_nx = iM1Write;
            mem_read_nx  = iM1Read & ~iM1Write;
            grant_nx     = 2'b10;
          end
        end
      end

      ST_BUSY: begin
        if (iMemRdy || expired) begin
          state_nx     = ST_DONE;
          mem_addr_nx  = '0;
          mem_data_nx  = '0;
          mem_read_nx  = 1'b0;
          mem_write_nx = 1'b0;
          grant_nx     = 2'b00;
          if (!iMemRdy) begin
            timeout_nx = 1'b1;
          end
          if (owner == ARB_M0) begin
            m0_rdy_nx = 1'b1;
            if (capture) m0_data_nx = ret_data;
          end else begin
            m1_rdy_nx = 1'b1;
            if (capture) m1_data_nx = ret_data;
          end
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state     <= ST_IDLE;
      oMemAddr  <= '0;
      oMemData  <= '0;
      oMemRead  <= 1'b0;
      oMemWrite <= 1'b0;
      oGrant    <= 2'b00;
      oM0Data   <= '0;
      oM1Data   <= '0;
      oM0Rdy    <= 1'b0;
      oM1Rdy    <= 1'b0;
      oTimeout  <= 1'b0;
    end else begin
      state     <= state_nx;
      oMemAddr  <= mem_addr_nx;
      oMemData  <= mem_data_nx;
      oMemRead  <= mem_read_nx;
      oMemWrite <= mem_write_nx;
      oGrant    <= grant_nx;
      oM0Data   <= m0_data_nx;
      oM1Data   <= m1_data_nx;
      oM0Rdy    <= m0_rdy_nx;
      oM1Rdy    <= m1_rdy_nx;
      oTimeout  <= timeout_nx;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        iClk, nRst;
  logic [31:0] iM0Addr, iM0Data, iM1Addr, iM1Data;
  logic        iM0Read, iM0Write, iM1Read, iM1Write;
  logic [31:0] oM0Data, oM1Data, oMemAddr, oMemData, iMemData;
  logic        oM0Rdy, oM1Rdy, oMemRead, oMemWrite, iMemRdy, oTimeout;
  logic [1:0]  oGrant, dbg_state;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .nRst(nRst),
    .iM0Addr(iM0Addr), .iM0Data(iM0Data), .iM0Read(iM0Read), .iM0Write(iM0Write),
    .iM1Addr(iM1Addr), .iM1Data(iM1Data), .iM1Read(iM1Read), .iM1Write(iM1Write),
    .oM0Data(oM0Data), .oM0Rdy(oM0Rdy), .oM1Data(oM1Data), .oM1Rdy(oM1Rdy),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .iMemData(iMemData), .iMemRdy(iMemRdy),
    .oGrant(oGrant), .oTimeout(oTimeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_last;
  logic [31:0] m_d0, m_d1;
  logic        m_to;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive_idle();
    iM0Read = 0; iM0Write = 0; iM1Read = 0; iM1Write = 0;
    iMemRdy = 0; iMemData = $urandom;
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_d0 = '0;
    m_d1 = '0;
    m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    drive_idle();
    iM0Addr = '0; iM0Data = '0; iM1Addr = '0; iM1Data = '0;
    tick();
    tick();
    nRst = 1'b1;
    model_reset();
  endtask

  // Grant rule: a lone requester wins; on a tie master 0 wins under fixed
  // priority, and the master not granted last time wins under round-robin.
  function automatic logic [1:0] model_grant(input logic q0, input logic q1);
    logic w;
    if (q0 && q1) w = RR ? ~m_last : 1'b0;
    else          w = q0 ? 1'b0 : 1'b1;
    return w ? 2'b10 : 2'b01;
  endfunction

  // One full transaction: request in IDLE, wt memory wait cycles, then DONE and
  // back to IDLE. Checks port contents, hold, completion, data and timeout flag.
  task automatic txn(input logic r0, input logic w0, input logic r1, input logic w1,
                     input logic [31:0] a0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [31:0] d1,
                     input int wt, input logic [31:0] rdata,
                     input logic [1:0] exp_g, input string tag);
    logic        win, wr, rd;
    logic [31:0] ea, ed, ev;
    bit          abort, hold_ok;
    int          busy_n;
    win   = exp_g[1];
    ea    = win ? a1 : a0;
    ed    = win ? d1 : d0;
    wr    = win ? w1 : w0;
    rd    = (win ? r1 : r0) & ~wr;
    abort = (TO != 0) && (wt >= int'(TO));
    busy_n = abort ? int'(TO) : wt + 1;
    if (abort)   exp_q.push_back(32'h0);
    else if (rd) exp_q.push_back(rdata);
    else         exp_q.push_back(win ? m_d1 : m_d0);

    iM0Addr = a0; iM0Data = d0; iM0Read = r0; iM0Write = w0;
    iM1Addr = a1; iM1Data = d1; iM1Read = r1; iM1Write = w1;
    iMemRdy = 0; iMemData = $urandom;
    tick();
    check({tag, "/grant"}, {62'd0, oGrant}, {62'd0, exp_g});
    check({tag, "/addr_data"}, {oMemAddr, oMemData}, {ea, ed});
    check({tag, "/strobes"}, {62'd0, oMemRead, oMemWrite}, {62'd0, rd, wr});

    hold_ok = 1'b1;
    for (int k = 1; k <= busy_n; k++) begin
      if (oGrant !== exp_g || oMemAddr !== ea || oMemData !== ed ||
          oMemRead !== rd || oMemWrite !== wr || oM0Rdy !== 1'b0 || oM1Rdy !== 1'b0)
        hold_ok = 1'b0;
      iMemRdy  = (k == wt + 1);
      iMemData = (k == wt + 1) ? rdata : $urandom;
      tick();
    end
    drive_idle();
    check({tag, "/busy_hold"}, {63'd0, hold_ok}, 64'd1);

    // DONE cycle
    ev = exp_q.pop_front();
    if (win) m_d1 = ev; else m_d0 = ev;
    m_to   = m_to | abort;
    m_last = win;
    check({tag, "/rdy"}, {62'd0, oM1Rdy, oM0Rdy}, {62'd0, exp_g});
    check({tag, "/done_port"}, {oMemAddr, oMemData}, 64'd0);
    check({tag, "/done_ctl"}, {61'd0, oGrant, oMemRead, oMemWrite}, 64'd0);
    check({tag, "/m0_data"}, {32'd0, oM0Data}, {32'd0, m_d0});
    check({tag, "/m1_data"}, {32'd0, oM1Data}, {32'd0, m_d1});
    check({tag, "/timeout"}, {63'd0, oTimeout}, {63'd0, m_to});

    tick();
    check({tag, "/rdy_clear"}, {62'd0, oM1Rdy, oM0Rdy}, 64'd0);
  endtask

  typedef struct {
    logic        r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    int          wt;
    logic [31:0] rdata;
    logic [1:0]  g_fp, g_rr;
  } vec_t;

  vec_t vt[10];

  initial begin
    // directed vectors, applied in order straight after reset
    vt[0] = '{1,0,0,0, 32'd20, 32'd0, 32'd0, 32'd0, 0, 32'd55, 2'b01, 2'b01};      // M0 read, zero wait
    vt[1] = '{0,0,0,1, 32'd0, 32'd0, 32'd21, 32'd1, 2, 32'hDEAD, 2'b10, 2'b10};    // M1 write, 2 waits
    vt[2] = '{1,0,1,0, 32'h100, 32'd0, 32'h200, 32'd0, 1, 32'hA1, 2'b01, 2'b01};   // tie 1
    vt[3] = '{1,0,1,0, 32'h100, 32'd0, 32'h200, 32'd0, 1, 32'hA2, 2'b01, 2'b10};   // tie 2
    vt[4] = '{1,0,1,0, 32'h100, 32'd0, 32'h200, 32'd0, 1, 32'hA3, 2'b01, 2'b01};   // tie 3
    vt[5] = '{1,0,1,0, 32'h100, 32'd0, 32'h200, 32'd0, 1, 32'hA4, 2'b01, 2'b10};   // tie 4
    vt[6] = '{1,1,0,0, 32'h30, 32'hABCD, 32'd0, 32'd0, 0, 32'h99, 2'b01, 2'b01};   // both strobes
    vt[7] = '{0,0,1,0, 32'd0, 32'd0, 32'h44, 32'd0, 3, 32'h5A5A, 2'b10, 2'b10};    // rdy on expiry edge
    vt[8] = '{1,0,0,0, 32'h50, 32'd0, 32'd0, 32'd0, 10, 32'h1234, 2'b01, 2'b01};   // timeout abort
    vt[9] = '{0,0,1,0, 32'd0, 32'd0, 32'h60, 32'd0, 0, 32'h77, 2'b10, 2'b10};      // normal after abort

    do_reset();
    check("reset/port", {oMemAddr, oMemData}, 64'd0);
    check("reset/data", {oM0Data, oM1Data}, 64'd0);
    check("reset/ctl", {57'd0, oGrant, oMemRead, oMemWrite, oM0Rdy, oM1Rdy, oTimeout}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      txn(vt[i].r0, vt[i].w0, vt[i].r1, vt[i].w1, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1,
          vt[i].wt, vt[i].rdata, RR ? vt[i].g_rr : vt[i].g_fp, $sformatf("vec%0d", i));
    end

    // hand sequence: timeout flag stays set across idle cycles
    tick();
    tick();
    check("sticky_timeout", {63'd0, oTimeout}, 64'd1);

    // hand sequence: reset during BUSY drops the transaction
    iM0Addr = 32'h40; iM0Read = 1'b1;
    tick();
    check("rst_mid/busy", {62'd0, oGrant}, 64'd1);
    nRst = 1'b0;
    tick();
    check("rst_mid/ctl", {57'd0, oGrant, oMemRead, oMemWrite, oM0Rdy, oM1Rdy, oTimeout}, 64'd0);
    check("rst_mid/port", {oMemAddr, oMemData}, 64'd0);
    check("rst_mid/data", {oM0Data, oM1Data}, 64'd0);
    nRst = 1'b1;
    drive_idle();
    model_reset();
    tick();
    check("rst_mid/no_rdy", {62'd0, oM1Rdy, oM0Rdy}, 64'd0);
    txn(1, 0, 0, 0, 32'h44, 32'd0, 32'd0, 32'd0, 0, 32'hC0FFEE, 2'b01, "rst_mid/retry");

    // randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      logic r0, w0, r1, w1;
      r0 = $urandom_range(0, 1); w0 = $urandom_range(0, 1);
      r1 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
      if (!(r0 | w0 | r1 | w1)) r0 = 1'b1;
      txn(r0, w0, r1, w1, $urandom, $urandom, $urandom, $urandom,
          $urandom_range(0, 5), $urandom, model_grant(r0 | w0, r1 | w1),
          $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter sharing the processor-side memory port (`oMemAddr`/`oMemData`/`iMemData`/`iMemRdy`/`oMemRead`/`oMemWrite`) between master 0, the `Processor` core, and master 1, a loader/debug agent that preloads instruction and data memory. It sits between `Processor` and the memory model or controller. It sequences one transaction at a time, returns read data to the owning master, and aborts transactions that never see `iMemRdy`.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `iMemRdy` before abort. 0 disables the timeout.
- `iClk` in 1: clock, rising edge.
- `nRst` in 1: synchronous, active-low reset.
- `iM0Addr` in 32: master 0 address. `iM1Addr` is the same for master 1.
- `iM0Data` in 32: master 0 write data. `iM1Data` is the same for master 1.
- `iM0Read`, `iM0Write` in 1 each: master 0 request strobes. `iM1Read`, `iM1Write` are the same for master 1.
- `oM0Data` out 32: read data returned to master 0. `oM1Data` is the same for master 1.
- `oM0Rdy` out 1: one-cycle completion pulse to master 0. `oM1Rdy` is the same for master 1.
- `oMemAddr` out 32: memory address.
- `oMemData` out 32: memory write data.
- `oMemRead`, `oMemWrite` out 1 each: memory strobes.
- `iMemData` in 32: memory read data.
- `iMemRdy` in 1: memory completion.
- `oGrant` out 2: one-hot current owner. `00` means none.
- `oTimeout` out 1: sticky abort flag.

## Operation
- **Request rule:** a master requests by asserting Read or Write.
  - It holds Addr and Data stable until its `oMxRdy` pulse.
  - If Read and Write are both high, the request is treated as a write.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - Samples requests. If any master is requesting, it picks a winner and moves to BUSY.
  - On that edge it registers the winner's Addr/Data/strobe onto the memory port and sets `oGrant`.
  - With no request it stays in IDLE.
- **BUSY:**
  - Memory outputs are held constant.
  - When `iMemRdy`=1 is sampled:
    - `iMemData` is captured into the owner's `oMxData` (for reads only; for writes `oMxData` is unchanged).
    - The owner's `oMxRdy` is set, strobes and `oGrant` are cleared, and the FSM moves to DONE.
- **DONE:** one cycle with `oMxRdy`=1, then IDLE. Requests are not sampled in DONE.
- **Arbitration (default):** fixed priority, master 0 before master 1.
- **Timeout:**
  - A counter runs in BUSY and clears on entry to BUSY.
  - When the count reaches `TIMEOUT_CYCLES` with no `iMemRdy`, the transaction aborts: owner `oMxData` = 32'h0000_0000, `oMxRdy` pulses, `oTimeout` is set, and the FSM goes to DONE.
  - `oTimeout` clears only on reset.
  - If `iMemRdy` arrives on the same edge as the timeout, `iMemRdy` wins and no abort occurs.
- **Memory port in IDLE and DONE:** `oMemAddr`/`oMemData` = 0 and the strobes are low.
- **Reset:**
  - All outputs go to 0 and the FSM goes to IDLE. This applies even mid-BUSY: the transaction is dropped with no `oMxRdy`.
  - The last-grant register resets to master 1.

## Timing
- All outputs are registered.
- Zero-wait memory (`iMemRdy` high in the first BUSY cycle):
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: BUSY, strobe visible.
  - Cycle 2: DONE, `oMxRdy`=1 and data valid.
  - Cycle 3: IDLE, next request sampled.
  - Throughput is one transaction per 3 cycles.
- Each memory wait cycle adds one BUSY cycle.
- A master that sees `oMxRdy` at the cycle-2 edge presents its next request (or deasserts) in cycle 3. A request still high in cycle 3 is treated as a new transaction.
- A request arriving in BUSY or DONE waits; it is never lost while held.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. When both masters request, the grant goes to the master not in the last-grant register.
  - The last-grant register updates on every grant.
  - Because the register resets to master 1, master 0 wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, master 0 always wins ties. The last-grant register is not built.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - master index constants `ARB_M0`=0 and `ARB_M1`=1;
  - the abort data constant 32'h0;
  - the default timeout value.
- Sub-module `mem_arb_timeout` is the watchdog. It has a clear input and an enable input, and produces an expired output. `TIMEOUT_CYCLES`=0 ties expired low.
- The FSM, picker and data muxing stay in the top module.

## Test plan
- **Master 0 read, zero wait:** M0 reads addr 20 and memory returns 55 with `iMemRdy`=1 immediately -> `oM0Data`=55, `oM0Rdy` pulses in cycle 2, `oGrant` is `01` during cycle 1 only.
- **Master 1 write, two wait states:** M1 writes 1 to addr 21 with `iMemRdy` delayed 2 cycles -> `oMemWrite` high for 3 cycles with addr 21 and data 1, `oM1Rdy` one pulse, `oM1Data` unchanged.
- **Simultaneous requests, held for 4 transactions:**
  - Without `MEM_ARB_RR_EN`: grant order M0,M0,M0,M0.
  - With `MEM_ARB_RR_EN`: grant order M0,M1,M0,M1.
- **Timeout:** `TIMEOUT_CYCLES`=4 and `iMemRdy` never asserts on an M0 read -> abort after 4 BUSY cycles, `oM0Data`=0, `oM0Rdy` pulses, `oTimeout`=1 and stays set. A following M1 read completes normally.
- **Reset mid-operation:** `nRst`=0 for one cycle during BUSY -> next cycle all outputs are 0 with no `oMxRdy`. A re-asserted request completes in 3 cycles.
- **Both strobes high:** M0 asserts Read and Write together -> `oMemWrite`=1 and `oMemRead`=0.
